change_dispenser: RTL and testbench

Pays out the customer's change as discrete coins once a purchase completes. Accepts a 7-bit change amount from the purchase path over a valid/ready handshake. Dispenses it greedily as 10/5/2/1 coins to the coin ejector over a req/ack handshake. Sits between the customer purchase logic (which produces the change) and the physical coin hopper.

---
 rtl/change_dispenser_if.sv | 26 ++
 rtl/change_dispenser.sv | 134 +++++++++++++
 tb/tb_change_dispenser.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// Handshake bundle between the purchase path, the change dispenser and the coin ejector.
//   change_valid/change_amount/change_ready : change amount hand-off (valid/ready)
//   coin_req/coin_type/coin_ack             : one-coin-at-a-time ejector request (req/ack)
// slave  : the dispenser side (consumes amounts, issues coin requests)
// master : the environment side (offers amounts, acknowledges coins)
interface change_dispenser_if;
    localparam int unsigned AMT_W  = 7;
    localparam int unsigned TYPE_W = 2;

    logic              change_valid;
    logic [AMT_W-1:0]  change_amount;
    logic              change_ready;
    logic              coin_req;
    logic [TYPE_W-1:0] coin_type;
    logic              coin_ack;

    modport master (
        output change_valid, change_amount, coin_ack,
        input  change_ready, coin_req, coin_type
    );

    modport slave (
        input  change_valid, change_amount, coin_ack,
        output change_ready, coin_req, coin_type
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change dispenser: accepts a change amount and pays it out as 10/5/2/1 coins,
// one req/ack transaction per coin, then pulses done and reports any unpaid residue.
// Optional macro COIN_INVENTORY_EN adds four per-denomination coin counters
// (loaded with COIN_INIT at reset and on refill in IDLE); empty denominations are skipped.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : change_dispenser_if.slave (change hand-off + coin ejector handshake)
//   busy       : payout in progress
//   done       : one-cycle pulse when a payout finishes
//   shortfall  : change left unpaid by the last payout (held until the next done)
//   refill     : reload coin inventory (inventory build only, IDLE only)
module change_dispenser #(
    parameter int unsigned COIN_INIT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    change_dispenser_if.slave      bus,
    output logic                   busy,
    output logic                   done,
    output logic [6:0]             shortfall,
    input  logic                   refill
);
    localparam int unsigned AMT_W  = 7;
    localparam int unsigned TYPE_W = 2;
    localparam int unsigned NCOIN  = 4;

    typedef enum logic [1:0] {IDLE, SELECT, REQ, DONE} state_t;

    state_t              state, state_nxt;
    logic [AMT_W-1:0]    remain, remain_nxt;
    logic [TYPE_W-1:0]   type_nxt;
    logic [TYPE_W-1:0]   sel_type;
    logic                sel_ok;
    logic [NCOIN-1:0]    avail;

    // Face value of each coin_type code.
    function automatic logic [AMT_W-1:0] denom(input logic [TYPE_W-1:0] t);
        case (t)
            2'd0:    denom = 7'd10;
            2'd1:    denom = 7'd5;
            2'd2:    denom = 7'd2;
            default: denom = 7'd1;
        endcase
    endfunction

`ifdef COIN_INVENTORY_EN
    logic [3:0] inv [NCOIN];

    // Per-denomination coin stock; a pending coin is only consumed by its ack.
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && refill)) begin
            for (int i = 0; i < NCOIN; i++) inv[i] <= 4'(COIN_INIT);
        end else if (state == REQ && bus.coin_ack) begin
            inv[bus.coin_type] <= inv[bus.coin_type] - 4'd1;
        end
    end

    always_comb begin
        avail = '0;
        for (int i = 0; i < NCOIN; i++) avail[i] = (inv[i] != 4'd0);
    end
`else
    logic unused_cfg;
    assign unused_cfg = refill ^ (COIN_INIT != 0);
    assign avail      = '1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state, coin selection and datapath next values.
    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        type_nxt   = bus.coin_type;
        sel_ok     = 1'b0;
        sel_type   = '0;
        // Scan smallest to largest so the largest qualifying coin wins.
        for (int i = NCOIN - 1; i >= 0; i--) begin
            if (avail[i] && remain >= denom(TYPE_W'(i))) begin
                sel_ok   = 1'b1;
                sel_type = TYPE_W'(i);
            end
        end
        case (state)
            IDLE: begin
                if (bus.change_valid) begin
                    remain_nxt = bus.change_amount;
                    state_nxt  = (bus.change_amount == '0) ? DONE : SELECT;
                end
            end
            SELECT: begin
                if (sel_ok) begin
                    type_nxt  = sel_type;
                    state_nxt = REQ;
                end else begin
                    state_nxt = DONE;
                end
            end
            REQ: begin
                if (bus.coin_ack) begin
                    remain_nxt = remain - denom(bus.coin_type);
                    state_nxt  = (remain_nxt != '0) ? SELECT : DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            remain           <= '0;
            bus.coin_type    <= '0;
            bus.coin_req     <= 1'b0;
            bus.change_ready <= 1'b1;
            busy             <= 1'b0;
            done             <= 1'b0;
            shortfall        <= '0;
        end else begin
            remain           <= remain_nxt;
            bus.coin_type    <= type_nxt;
            bus.coin_req     <= (state_nxt == REQ);
            bus.change_ready <= (state_nxt == IDLE);
            busy             <= (state_nxt != IDLE);
            done             <= (state_nxt == DONE);
            if (state_nxt == DONE) shortfall <= remain_nxt;
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// Randomized self-checking bench for change_dispenser against a greedy payout model.
module tb_change_dispenser;
`ifdef COIN_INVENTORY_EN
    localparam bit          INV_EN = 1'b1;
    localparam int unsigned INIT   = 1;
`else
    localparam bit          INV_EN = 1'b0;
    localparam int unsigned INIT   = 15;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       busy, done, refill;
    logic [6:0] shortfall;

    change_dispenser_if bus ();

    change_dispenser #(.COIN_INIT(INIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .shortfall (shortfall),
        .refill    (refill)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int coin_val [4] = '{10, 5, 2, 1};
    int inv_m    [4];
    int exp_q    [$];
    int exp_short;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reload();
        for (int i = 0; i < 4; i++) inv_m[i] = INIT;
    endtask

    // Greedy payout from the rules: largest coin not above the remainder and in stock.
    task automatic model_plan(input int amt);
        int  rem;
        bit  found;
        rem = amt;
        exp_q.delete();
        do begin
            found = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!found && coin_val[i] <= rem && (!INV_EN || inv_m[i] > 0)) begin
                    found = 1'b1;
                    exp_q.push_back(i);
                    rem -= coin_val[i];
                    if (INV_EN) inv_m[i]--;
                end
            end
        end while (found);
        exp_short = rem;
    endtask

    task automatic do_refill();
        @(negedge clk);
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        if (INV_EN) model_reload();
    endtask

    // One payout: dly = extra cycles before ack, tie_high = ack held high throughout,
    // inject = offer amount 50 while busy (must be ignored).
    task automatic run_payout(input int amt, input int dly, input bit tie_high, input bit inject);
        int t, k, held, d_eff, done_t;
        bit fin, prev_req;
        int cur_type;
        model_plan(amt);
        d_eff  = tie_high ? 0 : dly;
        done_t = 1 + exp_q.size() * (d_eff + 2) + ((exp_short > 0) ? 1 : 0);
        @(negedge clk);
        check("ready_before", bus.change_ready, 1);
        bus.change_valid  = 1'b1;
        bus.change_amount = 7'(amt);
        bus.coin_ack      = tie_high;
        t = 0; k = 0; held = 0; fin = 1'b0; prev_req = 1'b0; cur_type = 0;
        while (!fin && t < 400) begin
            @(negedge clk);
            t++;
            bus.change_valid  = inject && (t >= 2);
            bus.change_amount = inject ? 7'd50 : 7'(amt);
            check("ready_vs_busy", bus.change_ready, !busy);
            if (bus.coin_req) begin
                if (!prev_req) begin
                    k++;
                    held = 0;
                    cur_type = bus.coin_type;
                    if (k <= exp_q.size()) begin
                        check("coin_type", bus.coin_type, exp_q[k-1]);
                        check("coin_cycle", t, 2 + (k - 1) * (d_eff + 2));
                    end else begin
                        check("extra_coin", k, exp_q.size());
                    end
                end else begin
                    check("type_stable", bus.coin_type, cur_type);
                    held++;
                end
            end
            bus.coin_ack = tie_high || (bus.coin_req && held >= dly);
            prev_req = bus.coin_req;
            if (done) begin
                check("done_cycle", t, done_t);
                check("shortfall", shortfall, exp_short);
                check("coin_count", k, exp_q.size());
                bus.change_valid = 1'b0;
                fin = 1'b1;
            end
        end
        if (!fin) check("done_timeout", 0, 1);
        bus.change_valid = 1'b0;
        bus.coin_ack     = 1'b0;
        @(negedge clk);
        check("done_pulse", done, 0);
        check("ready_after", bus.change_ready, 1);
        check("busy_after", busy, 0);
    endtask

    task automatic reset_mid_payout();
        bit seen;
        @(negedge clk);
        bus.change_valid  = 1'b1;
        bus.change_amount = 7'd60;
        bus.coin_ack      = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            bus.change_valid = 1'b0;
            seen = bus.coin_req;
        end
        check("req_before_rst", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_coin_req", bus.coin_req, 0);
        check("rst_ready", bus.change_ready, 1);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        model_reload();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        refill            = 1'b0;
        bus.change_valid  = 1'b0;
        bus.change_amount = '0;
        bus.coin_ack      = 1'b0;
        model_reload();
        repeat (2) @(negedge clk);
        check("rst_state_ready", bus.change_ready, 1);
        check("rst_state_req", bus.coin_req, 0);
        check("rst_state_type", bus.coin_type, 0);
        check("rst_state_busy", busy, 0);
        check("rst_state_done", done, 0);
        check("rst_state_short", shortfall, 0);
        rst = 1'b0;

        run_payout(38, 0, 1'b1, 1'b0);
        run_payout(0, 0, 1'b1, 1'b0);
        run_payout(7, 3, 1'b0, 1'b0);
        do_refill();
        run_payout(10, 0, 1'b1, 1'b0);
        do_refill();
        run_payout(60, 1, 1'b0, 1'b1);
        reset_mid_payout();
        run_payout(127, 0, 1'b1, 1'b0);

        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 3) == 0) do_refill();
            run_payout(int'($urandom_range(0, 127)), int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
